// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle RV32M multiply/divide unit.
// Multiplies use radix-2 shift-add and divides use restoring shift-subtract,
// one bit per clock. Divide-by-zero and signed overflow finish right after
// launch. Optional build macro MULDIV_FAST_MUL_EN replaces the iterative
// multiply with a single-cycle combinational multiply; divides are unchanged.
module mul_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [3:0]            ALU_Operation_i,
   input  logic [DATA_WIDTH-1:0] A_i,
   input  logic [DATA_WIDTH-1:0] B_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

   state_t          state_r, state_s;
   logic [2:0]      op_r, op_s;          // op code without the always-set MSB
   logic [CW-1:0]   cnt_r, cnt_s;
   logic [2*W-1:0]  prod_r, prod_s;      // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
   logic [W-1:0]    mcand_r, mcand_s;    // mul: multiplicand; div: divisor
   logic            sa_r, sa_s;          // effective sign of A
   logic            sb_r, sb_s;          // effective sign of B
   logic [W-1:0]    result_r, result_s;
   logic            busy_r, done_r;

   // operand decode for a launch request
   logic            in_div_s, in_signed_a_s, in_signed_b_s, in_sa_s, in_sb_s;
   logic            div_zero_s, div_ovf_s;
   logic [W-1:0]    mag_a_s, mag_b_s, special_res_s;

   assign in_div_s      = ALU_Operation_i[2];
   assign in_signed_a_s = in_div_s ? ~ALU_Operation_i[0]
                                   : (ALU_Operation_i[1:0] == 2'b01) || (ALU_Operation_i[1:0] == 2'b10);
   assign in_signed_b_s = in_div_s ? ~ALU_Operation_i[0] : (ALU_Operation_i[1:0] == 2'b01);
   assign in_sa_s       = in_signed_a_s & A_i[W-1];
   assign in_sb_s       = in_signed_b_s & B_i[W-1];
   assign mag_a_s       = in_sa_s ? -A_i : A_i;
   assign mag_b_s       = in_sb_s ? -B_i : B_i;
   assign div_zero_s    = in_div_s && (B_i == {W{1'b0}});
   assign div_ovf_s     = in_div_s && !ALU_Operation_i[0] &&
                          (A_i == {1'b1, {(W-1){1'b0}}}) && (B_i == {W{1'b1}});
   // divide by zero: quotient all ones, remainder = dividend; overflow: quotient = A, remainder 0
   assign special_res_s = div_zero_s ? (ALU_Operation_i[1] ? A_i : {W{1'b1}})
                                     : (ALU_Operation_i[1] ? {W{1'b0}} : A_i);

   // one iteration step of each algorithm
   logic [W:0]      mul_sum_s, div_shift_s, div_diff_s;
   logic            div_ge_s;
   logic [W-1:0]    div_rem_s;

   assign mul_sum_s   = {1'b0, prod_r[2*W-1:W]} + (prod_r[0] ? {1'b0, mcand_r} : {(W+1){1'b0}});
   assign div_shift_s = {prod_r[2*W-1:W], prod_r[W-1]};
   assign div_ge_s    = div_shift_s >= {1'b0, mcand_r};
   assign div_diff_s  = div_shift_s - {1'b0, mcand_r};
   assign div_rem_s   = div_ge_s ? div_diff_s[W-1:0] : div_shift_s[W-1:0];

   // sign correction and output selection
   logic            neg_s;
   logic [2*W-1:0]  mul_full_s;
   logic [W-1:0]    quot_s, rem_s, fix_res_s;

   assign neg_s = sa_r ^ sb_r;
`ifdef MULDIV_FAST_MUL_EN
   // signed 33x33 multiply: operands sign-extended from their effective sign bit
   logic [2*W-1:0]  fast_a_s, fast_b_s;
   assign fast_a_s   = {{W{sa_r}}, mcand_r};
   assign fast_b_s   = {{W{sb_r}}, prod_r[W-1:0]};
   assign mul_full_s = fast_a_s * fast_b_s;
`else
   assign mul_full_s = neg_s ? -prod_r : prod_r;
`endif
   assign quot_s    = neg_s ? -prod_r[W-1:0] : prod_r[W-1:0];
   assign rem_s     = sa_r ? -prod_r[2*W-1:W] : prod_r[2*W-1:W];
   assign fix_res_s = op_r[2] ? (op_r[1] ? rem_s : quot_s)
                              : ((op_r[1:0] == 2'b00) ? mul_full_s[W-1:0] : mul_full_s[2*W-1:W]);

   // next-state and datapath update logic
   always_comb begin
      state_s  = state_r;
      op_s     = op_r;
      cnt_s    = cnt_r;
      prod_s   = prod_r;
      mcand_s  = mcand_r;
      sa_s     = sa_r;
      sb_s     = sb_r;
      result_s = result_r;
      case (state_r)
         IDLE: begin
            if (start_i && ALU_Operation_i[3]) begin
               op_s  = ALU_Operation_i[2:0];
               cnt_s = {CW{1'b0}};
               sa_s  = in_sa_s;
               sb_s  = in_sb_s;
               if (div_zero_s || div_ovf_s) begin
                  result_s = special_res_s;
                  state_s  = DONE;
               end else if (in_div_s) begin
                  mcand_s = mag_b_s;
                  prod_s  = {{W{1'b0}}, mag_a_s};
                  state_s = ITER;
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  mcand_s = A_i;
                  prod_s  = {{W{1'b0}}, B_i};
                  state_s = FIX;
`else
                  mcand_s = mag_a_s;
                  prod_s  = {{W{1'b0}}, mag_b_s};
                  state_s = ITER;
`endif
               end
            end else begin
               state_s = IDLE;
            end
         end
         ITER: begin
            if (op_r[2]) begin
               prod_s = {div_rem_s, prod_r[W-2:0], div_ge_s};
            end else begin
               prod_s = {mul_sum_s, prod_r[W-1:1]};
            end
            cnt_s = cnt_r + CW'(1);
            if (cnt_r == CW'(W-1)) begin
               state_s = FIX;
            end else begin
               state_s = ITER;
            end
         end
         FIX: begin
            result_s = fix_res_s;
            state_s  = DONE;
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // state, datapath and registered status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         op_r     <= 3'b000;
         cnt_r    <= {CW{1'b0}};
         prod_r   <= {(2*W){1'b0}};
         mcand_r  <= {W{1'b0}};
         sa_r     <= 1'b0;
         sb_r     <= 1'b0;
         result_r <= {W{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         op_r     <= op_s;
         cnt_r    <= cnt_s;
         prod_r   <= prod_s;
         mcand_r  <= mcand_s;
         sa_r     <= sa_s;
         sb_r     <= sb_s;
         result_r <= result_s;
         busy_r   <= (state_s != IDLE);
         done_r   <= (state_s == DONE);
      end
   end

   assign result_o = result_r;
   assign busy_o   = busy_r;
   assign done_o   = done_r;

endmodule
